ultrasonic_trigger_ctrl: RTL
============================

# ultrasonic_trigger_ctrl

- Front-end stage for the HC-SR04-style ranging sensor; sits directly upstream of the distance counter.
- Issues a periodic trigger pulse and synchronises the asynchronous echo input.
- Qualifies each echo against wait and length timeouts, then drives `disStart` high exactly for the valid echo window, so the counter measures pulse width in `clk` cycles.
- Also reports per-frame completion and timeout status.

## Interface

Parameters (all 32-bit integer, counts in `clk` cycles):
- `TRIG_CYCLES`, default 1000: trigger pulse width (10 µs at 100 MHz).
- `ECHO_WAIT_CYCLES`, default 100000: maximum wait from trigger end to echo rise.
- `ECHO_MAX_CYCLES`, default 3000000: maximum accepted echo-high length.
- `PERIOD_CYCLES`, default 6000000: trigger-to-trigger frame period (60 ms).
- Legality: all ≥ 2; `PERIOD_CYCLES` > `TRIG_CYCLES` + `ECHO_WAIT_CYCLES` + `ECHO_MAX_CYCLES` + 4.

Ports:
- `clk` in 1: single system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: run periodic measurements.
- `echo` in 1: raw sensor echo, asynchronous to `clk`.
- `trig` out 1: sensor trigger pulse.
- `disStart` out 1: qualified echo window, consumed by the distance counter.
- `busy` out 1: high in any state except IDLE.
- `frame_done` out 1: one-cycle pulse on a normal echo fall.
- `timeout` out 1: one-cycle pulse on an echo-wait or echo-length timeout.

## Operation

- Echo synchroniser: two flops, `echo` → `echo_s1` → `echo_s`, plus a delay flop `echo_d` holding the previous `echo_s`.
  - Rise event: `echo_s & ~echo_d`.
  - Fall event: `~echo_s & echo_d`.
- Counters, both 32-bit and saturating at their maximum (no wrap-around):
  - `phase_cnt`: cleared on every state entry.
  - `frame_cnt`: cleared on TRIG entry.
- FSM states: IDLE, TRIG, WAIT_ECHO, ECHO_HIGH, HOLDOFF.
- IDLE:
  - All outputs 0.
  - `enable`=1 → TRIG.
- TRIG:
  - `trig`=1.
  - At `phase_cnt`==`TRIG_CYCLES`-1 → WAIT_ECHO.
- WAIT_ECHO:
  - Rise event → ECHO_HIGH.
  - Otherwise, at `phase_cnt`==`ECHO_WAIT_CYCLES`-1 → HOLDOFF with a `timeout` pulse.
  - An echo already high on entry (stale or stuck) is not a rise and is ignored.
  - If the rise event and the wait timeout fall in the same cycle, the rise wins.
- ECHO_HIGH:
  - `disStart`=1.
  - Fall event → HOLDOFF with a `frame_done` pulse.
  - Otherwise, at `phase_cnt`==`ECHO_MAX_CYCLES`-1 → HOLDOFF with a `timeout` pulse; `disStart` drops on the same edge.
  - If the fall event and the length timeout fall in the same cycle, the fall wins (`frame_done` only).
- HOLDOFF:
  - Stays until `frame_cnt` ≥ `PERIOD_CYCLES`-1 and `echo_s`==0. An echo still high stretches the frame.
  - Then `enable`=1 → TRIG; `enable`=0 → IDLE.
- `enable` is sampled only in IDLE and at HOLDOFF exit. Deasserting it mid-frame lets the current frame complete.
- Reset, including mid-operation: state IDLE; all counters, synchroniser flops and outputs (`trig`, `disStart`, `busy`, `frame_done`, `timeout`) go to 0 immediately.

## Timing

- All outputs are registered and change only on `clk` rising edges (apart from asynchronous reset).
- `trig` rises on the edge that enters TRIG and stays high exactly `TRIG_CYCLES` cycles.
- Trigger period:
  - Consecutive `trig` rising edges are exactly `PERIOD_CYCLES` cycles apart when `enable` stays 1 and `echo_s` is low by frame end.
  - The period is longer by the number of extra cycles `echo_s` stays high.
- `disStart` latency:
  - It rises 3 edges after the first edge that samples `echo` high (2 synchroniser edges, then the state register).
  - It falls 3 edges after the first edge that samples `echo` low.
  - The `disStart` high width therefore equals the sampled echo width, ±1 cycle of asynchronous sampling uncertainty.
- `frame_done` and `timeout` are high for exactly one cycle, on the same edge as the HOLDOFF entry. They are never high together.
- `busy` becomes 1 on TRIG entry and 0 on IDLE entry.

## Test plan

Bench parameters: `TRIG_CYCLES`=4, `ECHO_WAIT_CYCLES`=20, `ECHO_MAX_CYCLES`=50, `PERIOD_CYCLES`=100.

1. Reset, then `enable`=1 at cycle 0:
   - `trig`=1 for exactly 4 cycles.
   - Next `trig` rise 100 cycles later.
   - `busy`=1 throughout.
2. Echo high 30 cycles, starting 5 cycles after `trig` falls:
   - `disStart` rises 3 edges after echo and is high 30 cycles.
   - One `frame_done` pulse; `timeout` stays 0.
3. No echo:
   - `timeout` pulses 20 cycles after `trig` falls; `disStart` stays 0.
   - Next `trig` still at +100.
4. Echo stuck high from before trigger:
   - No `disStart` assertion; `timeout` after the 20-cycle wait.
   - HOLDOFF stretches the period until echo falls, then the next trigger is issued.
5. Echo high 80 cycles:
   - `disStart` high exactly 50 cycles, then `timeout` pulse; `frame_done` stays 0.
   - Next `trig` rises when `frame_cnt` reaches 99 and echo is low.
6. Control boundaries:
   - `enable` dropped during ECHO_HIGH: current frame finishes with `frame_done`, then IDLE with `busy`=0.
   - `rst_n` pulsed low mid-ECHO_HIGH: `disStart`, `trig` and `busy` go to 0 immediately; restart is clean.

Source files
------------

// File: rtl/ultrasonic_trigger_ctrl.sv
// rtl/ultrasonic_trigger_ctrl.sv - HC-SR04 trigger generator and echo qualifier
// Produces a periodic trigger and gates disStart over each qualified echo window.
module ultrasonic_trigger_ctrl #(
  parameter int unsigned TRIG_CYCLES      = 1000,
  parameter int unsigned ECHO_WAIT_CYCLES = 100000,
  parameter int unsigned ECHO_MAX_CYCLES  = 3000000,
  parameter int unsigned PERIOD_CYCLES    = 6000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic echo,
  output logic trig,
  output logic disStart,
  output logic busy,
  output logic frame_done,
  output logic timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_ECHO,
    S_ECHO_HIGH,
    S_HOLDOFF
  } state_t;

  state_t      state, state_nxt;
  logic        echo_s1, echo_s, echo_d;
  logic        echo_rise, echo_fall;
  logic        done_nxt, timeout_nxt;
  logic [31:0] phase_cnt, frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_s1 <= 1'b0;
      echo_s  <= 1'b0;
      echo_d  <= 1'b0;
    end else begin
      echo_s1 <= echo;
      echo_s  <= echo_s1;
      echo_d  <= echo_s;
    end
  end

  assign echo_rise = echo_s & ~echo_d;
  assign echo_fall = ~echo_s & echo_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    done_nxt    = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable) state_nxt = S_TRIG;
      end
      S_TRIG: begin
        if (phase_cnt == TRIG_CYCLES - 1) state_nxt = S_WAIT_ECHO;
      end
      S_WAIT_ECHO: begin
        // Only an edge counts: a level already high on entry is stale.
        if (echo_rise) begin
          state_nxt = S_ECHO_HIGH;
        end else if (phase_cnt == ECHO_WAIT_CYCLES - 1) begin
          state_nxt   = S_HOLDOFF;
          timeout_nxt = 1'b1;
        end
      end
      S_ECHO_HIGH: begin
        if (echo_fall) begin
          state_nxt = S_HOLDOFF;
          done_nxt  = 1'b1;
        end else if (phase_cnt == ECHO_MAX_CYCLES - 1) begin
          state_nxt   = S_HOLDOFF;
          timeout_nxt = 1'b1;
        end
      end
      S_HOLDOFF: begin
        if (frame_cnt >= PERIOD_CYCLES - 1 && !echo_s)
          state_nxt = enable ? S_TRIG : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_cnt <= '0;
      frame_cnt <= '0;
    end else begin
      if (state_nxt != state)  phase_cnt <= '0;
      else if (phase_cnt != '1) phase_cnt <= phase_cnt + 32'd1;

      if (state_nxt == S_TRIG && state != S_TRIG) frame_cnt <= '0;
      else if (frame_cnt != '1)                   frame_cnt <= frame_cnt + 32'd1;
    end
  end

  // Outputs follow the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig       <= 1'b0;
      disStart   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      trig       <= (state_nxt == S_TRIG);
      disStart   <= (state_nxt == S_ECHO_HIGH);
      busy       <= (state_nxt != S_IDLE);
      frame_done <= done_nxt;
      timeout    <= timeout_nxt;
    end
  end

endmodule
